phy_tx_scheduler: RTL and testbench
===================================

# phy_tx_scheduler

Sits between the protocol layer and the PHY transmit request interface (`pl2phy_tx_packet_en/type`, `phy2pl_tx_packet_done/result`) and shares it between two requesters. Port 0 is the reset path (Hard/Cable Reset) and port 1 is the message path. The block arbitrates with fixed priority, defers message transmission while a receive is in progress, and retries failed attempts after a backoff. It also guards each attempt with a done-timeout and returns a single done/result handshake per request.

## Interface
Parameters:
- `MAX_RETRY`, 2: retries after the first failed attempt (total attempts = 1+MAX_RETRY).
- `BACKOFF_CYCLES`, 64: clk cycles waited between a failed attempt and its retry; must be ≥1.
- `DONE_TIMEOUT`, 4096: cycles allowed from `tx_packet_en` to `tx_packet_done`; must be ≥2.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset; synchronous, active-high.
- `req0_en`  in  1  reset-path request; level, held until `req0_done`.
- `req0_type`  in  3  packet type for port 0; sampled at grant.
- `req1_en`  in  1  message-path request; level, held until `req1_done`.
- `req1_type`  in  3  packet type for port 1; sampled at grant.
- `req0_done`, `req1_done`  out  1 each  one-cycle completion pulse.
- `req_result`  out  1  1 = sent, 0 = failed; valid only with a done pulse.
- `rx_busy`  in  1  PHY receive in progress (`phy2pl_rx_packet_en` window).
- `tx_packet_en`  out  1  one-cycle PHY transmit strobe.
- `tx_packet_type`  out  3  type sent to the PHY; stable from strobe until done.
- `tx_packet_done`  in  1  PHY completion pulse.
- `tx_packet_result`  in  1  PHY result: 1 = ok, 0 = line not idle or aborted.
- `sched_busy`  out  1  state ≠ IDLE.
- `sched_owner`  out  1  granted port; valid while `sched_busy`.
- `timeout_flag`  out  1  sticky; set on a done-timeout, cleared at the next grant.

## Operation
- The state machine has five states: IDLE, ISSUE, WAIT_DONE, BACKOFF, REPORT.
- IDLE arbitration:
  - `req0_en` wins unconditionally.
  - `req1_en` is granted only when `!rx_busy` and `!req0_en`.
  - On grant, the block latches the owner and type, clears the attempt counter and `timeout_flag`, then goes to ISSUE.
- ISSUE:
  - Drives `tx_packet_en` for exactly one cycle and loads the timeout counter, then goes to WAIT_DONE.
  - If owner = 1 and `rx_busy` is high, it stays in ISSUE without strobing. This applies to retries too.
- WAIT_DONE:
  - On `tx_packet_done` with result 1, go to REPORT with result 1.
  - On `tx_packet_done` with result 0 and attempts < MAX_RETRY, increment the attempt counter and go to BACKOFF.
  - On `tx_packet_done` with result 0 and retries exhausted, go to REPORT with result 0.
  - If the timeout counter expires first, set `timeout_flag` and go to REPORT with result 0. A timeout is never retried.
- BACKOFF:
  - Counts `BACKOFF_CYCLES`, then goes to ISSUE.
  - If owner = 1 and `req0_en` rises, port 1 is preempted: go to REPORT with result 0, and port 0 is granted from IDLE next.
- REPORT: pulses the owner's done with `req_result` for one cycle, then returns to IDLE.
- `tx_packet_done` arriving outside WAIT_DONE is ignored.
- A requester dropping its `_en` mid-transaction does not abort the transaction; its done pulse still fires.
- Counter widths are `$clog2(N+1)`. Counters saturate and never wrap.

## Timing
- Every output is 0 in the cycle after `rst` is sampled high.
- Reset mid-transaction returns the block to IDLE with no done pulse.
- Grant-to-strobe latency:
  - Request sampled in IDLE at edge t puts the block in ISSUE.
  - `tx_packet_en` is high in cycle t+1 (one cycle after the grant edge).
- Completion latency:
  - `tx_packet_done` at cycle k gives REPORT, with the done pulse at k+1.
  - The block is back in IDLE at k+2, and a new grant is possible at k+2.
- Retry spacing: the next `tx_packet_en` comes `BACKOFF_CYCLES`+1 cycles after the failing done, provided `rx_busy` is low.
- Timeout: if no done arrives within `DONE_TIMEOUT` cycles after the strobe, REPORT follows on the next cycle. If done and expiry land in the same cycle, done wins.
- `tx_packet_type` holds the latched value from ISSUE until REPORT. It is 0 in IDLE.

## Structure
- Shared package `pd_phy_pkg`:
  - Packet-type constants SOP=0, SOP'=1, SOP''=2, HARD_RESET=3, CABLE_RESET=4, BIST=5.
  - The scheduler state enum.
- One sub-module, `phy_tx_sched_timer`, serves as both the backoff counter and the timeout counter, since they are never active together.
  - Inputs: `load`, `load_val`, `en`.
  - Output: `expired`.
- Remaining RTL, about 200 lines, is the FSM, arbitration and registered outputs.

## Test plan
- **Single send:** `req1_en` with type 0, and done/result = 1 returned 10 cycles after the strobe → `tx_packet_en` high 1 cycle after the request; `req1_done` = 1 and `req_result` = 1 exactly 1 cycle after done.
- **Priority:** `req0_en` (type 3) and `req1_en` rise in the same cycle → port 0 strobed first; port 1 strobed at done0+2 cycles after the port-0 done; two done pulses in that order.
- **Retry exhaustion:** PHY returns result 0 on every attempt with MAX_RETRY = 2 → 3 strobes, each spaced 65 cycles after the preceding done; then `req1_done` with result 0.
- **Receive deferral:** `rx_busy` high for 50 cycles while `req1_en` is asserted → no strobe until the cycle after `rx_busy` falls; `req0_en` asserted under `rx_busy` is strobed immediately.
- **Timeout and preemption:**
  - With DONE_TIMEOUT = 16 and no done returned → done pulse with result 0 and `timeout_flag` = 1.
  - With port 1 in BACKOFF and `req0_en` asserted → `req1_done`/0, then port 0 strobed.
- **Reset mid-WAIT_DONE:** `rst` pulsed while waiting for done → all outputs 0 next cycle; no done pulse; a new request is served normally.

Source files
------------

// File: rtl/pd_phy_pkg.sv
// Shared PHY-side definitions: packet-type codes and the transmit scheduler state encoding.
package pd_phy_pkg;

  localparam logic [2:0] PKT_SOP         = 3'd0;
  localparam logic [2:0] PKT_SOP_P       = 3'd1;
  localparam logic [2:0] PKT_SOP_PP      = 3'd2;
  localparam logic [2:0] PKT_HARD_RESET  = 3'd3;
  localparam logic [2:0] PKT_CABLE_RESET = 3'd4;
  localparam logic [2:0] PKT_BIST        = 3'd5;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ISSUE     = 3'd1,
    ST_WAIT_DONE = 3'd2,
    ST_BACKOFF   = 3'd3,
    ST_REPORT    = 3'd4
  } sched_state_t;

endpackage

// File: rtl/phy_tx_sched_timer.sv
// Saturating down-counter shared by the retry backoff and the done-timeout.
// Loading N makes expired assert after N enabled cycles.
module phy_tx_sched_timer #(
  parameter int W = 13
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic         expired
);

  logic [W-1:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && (cnt != '0)) begin
      cnt <= cnt - W'(1);
    end
  end

  assign expired = (cnt == '0);

endmodule

// File: rtl/phy_tx_scheduler.sv
// Shares the PHY transmit request interface between the reset path (port 0) and the
// message path (port 1): fixed priority, receive deferral, retry with backoff, done-timeout.
module phy_tx_scheduler
  import pd_phy_pkg::*;
#(
  parameter int MAX_RETRY      = 2,
  parameter int BACKOFF_CYCLES = 64,
  parameter int DONE_TIMEOUT   = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_en,
  input  logic [2:0] req0_type,
  input  logic       req1_en,
  input  logic [2:0] req1_type,
  output logic       req0_done,
  output logic       req1_done,
  output logic       req_result,
  input  logic       rx_busy,
  output logic       tx_packet_en,
  output logic [2:0] tx_packet_type,
  input  logic       tx_packet_done,
  input  logic       tx_packet_result,
  output logic       sched_busy,
  output logic       sched_owner,
  output logic       timeout_flag
);

  localparam int TMR_MAX = (BACKOFF_CYCLES > DONE_TIMEOUT) ? BACKOFF_CYCLES : DONE_TIMEOUT;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);
  localparam int ATT_W   = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  // Loads are one short because the transition edge that loads the timer counts as cycle one.
  localparam logic [TMR_W-1:0] BACKOFF_LOAD = TMR_W'(BACKOFF_CYCLES - 1);
  localparam logic [TMR_W-1:0] TIMEOUT_LOAD = TMR_W'(DONE_TIMEOUT - 1);
  localparam logic [ATT_W-1:0] ATT_LIMIT    = ATT_W'(MAX_RETRY);

  sched_state_t     state;
  logic             owner;
  logic [ATT_W-1:0] attempts;
  logic             result_q;

  logic             strobe_ok;
  logic             retry_ok;
  logic             tmr_load;
  logic             tmr_en;
  logic             tmr_expired;
  logic [TMR_W-1:0] tmr_load_val;

  // Message traffic never strobes while the PHY is receiving, first attempt or retry.
  assign strobe_ok    = (state == ST_ISSUE) && !(owner && rx_busy);
  assign retry_ok     = (state == ST_WAIT_DONE) && tx_packet_done && !tx_packet_result &&
                        (attempts < ATT_LIMIT);
  assign tmr_load     = strobe_ok || retry_ok;
  assign tmr_load_val = strobe_ok ? TIMEOUT_LOAD : BACKOFF_LOAD;
  assign tmr_en       = (state == ST_WAIT_DONE) || (state == ST_BACKOFF);

  assign sched_busy  = (state != ST_IDLE);
  assign sched_owner = owner;

  phy_tx_sched_timer #(.W(TMR_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_load_val),
    .en       (tmr_en),
    .expired  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      owner          <= 1'b0;
      attempts       <= '0;
      result_q       <= 1'b0;
      tx_packet_en   <= 1'b0;
      tx_packet_type <= '0;
      req0_done      <= 1'b0;
      req1_done      <= 1'b0;
      req_result     <= 1'b0;
      timeout_flag   <= 1'b0;
    end else begin
      tx_packet_en <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req_result   <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (req0_en || (req1_en && !rx_busy)) begin
            owner          <= !req0_en;
            tx_packet_type <= req0_en ? req0_type : req1_type;
            attempts       <= '0;
            timeout_flag   <= 1'b0;
            state          <= ST_ISSUE;
          end
        end

        ST_ISSUE: begin
          if (strobe_ok) begin
            tx_packet_en <= 1'b1;
            state        <= ST_WAIT_DONE;
          end
        end

        // A done landing on the expiry cycle is honoured before the timeout.
        ST_WAIT_DONE: begin
          if (tx_packet_done) begin
            if (tx_packet_result) begin
              result_q <= 1'b1;
              state    <= ST_REPORT;
            end else if (retry_ok) begin
              attempts <= attempts + ATT_W'(1);
              state    <= ST_BACKOFF;
            end else begin
              result_q <= 1'b0;
              state    <= ST_REPORT;
            end
          end else if (tmr_expired) begin
            timeout_flag <= 1'b1;
            result_q     <= 1'b0;
            state        <= ST_REPORT;
          end
        end

        ST_BACKOFF: begin
          if (owner && req0_en) begin
            result_q <= 1'b0;
            state    <= ST_REPORT;
          end else if (tmr_expired) begin
            state <= ST_ISSUE;
          end
        end

        ST_REPORT: begin
          req0_done      <= !owner;
          req1_done      <= owner;
          req_result     <= result_q;
          tx_packet_type <= '0;
          owner          <= 1'b0;
          state          <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_phy_tx_scheduler.sv
// Self-checking bench for phy_tx_scheduler: directed scenarios plus randomized transactions
// compared against a transaction-level timing model.
module tb_phy_tx_scheduler;
  import pd_phy_pkg::*;

  localparam int MAX_RETRY = 2;
  localparam int BACKOFF   = 64;
  localparam int TO        = 16;
  localparam int LAT_MAX   = 20;
  localparam int BUDGET    = 800;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req0_en = 1'b0;
  logic [2:0] req0_type = 3'd0;
  logic       req1_en = 1'b0;
  logic [2:0] req1_type = 3'd0;
  logic       rx_busy = 1'b0;
  logic       tx_packet_done = 1'b0;
  logic       tx_packet_result = 1'b0;
  logic       req0_done, req1_done, req_result;
  logic       tx_packet_en;
  logic [2:0] tx_packet_type;
  logic       sched_busy, sched_owner, timeout_flag;

  phy_tx_scheduler #(
    .MAX_RETRY      (MAX_RETRY),
    .BACKOFF_CYCLES (BACKOFF),
    .DONE_TIMEOUT   (TO)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .req0_en          (req0_en),
    .req0_type        (req0_type),
    .req1_en          (req1_en),
    .req1_type        (req1_type),
    .req0_done        (req0_done),
    .req1_done        (req1_done),
    .req_result       (req_result),
    .rx_busy          (rx_busy),
    .tx_packet_en     (tx_packet_en),
    .tx_packet_type   (tx_packet_type),
    .tx_packet_done   (tx_packet_done),
    .tx_packet_result (tx_packet_result),
    .sched_busy       (sched_busy),
    .sched_owner      (sched_owner),
    .timeout_flag     (timeout_flag)
  );

  always #5 clk = ~clk;

  typedef struct { int lat; int res; } resp_t;
  typedef struct { int cyc; int typ; int owner; int busy; } strobe_t;
  typedef struct { int cyc; int port; int res; int to; int busy; int dual; } done_t;

  resp_t   plan[$];
  resp_t   mplan[$];
  strobe_t obs_s[$];
  strobe_t exp_s[$];
  done_t   obs_d[$];
  done_t   exp_d[$];

  int cyc = 0;
  int done_cnt0 = 0;
  int done_cnt1 = 0;
  int n_checks = 0;
  int n_fail = 0;

  int pend_due = 0;
  int pend_res = 0;
  bit pend = 1'b0;

  // Monitor: cycle index is the number of rising edges so far; samples 1 unit after the edge.
  initial forever begin
    @(posedge clk);
    cyc++;
    #1;
    if (tx_packet_en)
      obs_s.push_back('{cyc, int'(tx_packet_type), int'(sched_owner), int'(sched_busy)});
    if (req0_done || req1_done) begin
      obs_d.push_back('{cyc, int'(req1_done), int'(req_result), int'(timeout_flag),
                        int'(sched_busy), int'(req0_done && req1_done)});
      if (req0_done) done_cnt0++;
      if (req1_done) done_cnt1++;
    end
  end

  // PHY responder: each strobe consumes one planned response; latencies beyond TO still
  // deliver a late done, which must be ignored.
  initial forever begin
    resp_t r;
    @(negedge clk);
    // NOTE: testbench inputs are driven with blocking assignments on the falling edge.
    tx_packet_done   = 1'b0;
    tx_packet_result = 1'b0;
    if (tx_packet_en && plan.size() > 0) begin
      r        = plan.pop_front();
      pend     = 1'b1;
      pend_due = cyc + r.lat - 1;
      pend_res = r.res;
    end
    if (pend && cyc == pend_due) begin
      tx_packet_done   = 1'b1;
      tx_packet_result = pend_res[0];
      pend             = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int outs_vec();
    return int'({tx_packet_en, tx_packet_type, req0_done, req1_done, req_result,
                 sched_busy, sched_owner, timeout_flag});
  endfunction

  task automatic add_plan(input int lat, input int res);
    plan.push_back('{lat, res});
    mplan.push_back('{lat, res});
  endtask

  // Transaction model: given the first strobe cycle, walk the attempts and predict every
  // strobe and the single done pulse.
  task automatic model_txn(input int s0, input int port, input int typ, output int done_cyc);
    int    s;
    bit    fin;
    resp_t r;
    s = s0;
    fin = 1'b0;
    done_cyc = 0;
    for (int i = 0; i <= MAX_RETRY && !fin; i++) begin
      r = mplan.pop_front();
      exp_s.push_back('{s, typ, port, 1});
      if (r.lat > TO) begin
        done_cyc = s + TO + 1;
        exp_d.push_back('{done_cyc, port, 0, 1, 0, 0});
        fin = 1'b1;
      end else if (r.res != 0) begin
        done_cyc = s + r.lat + 1;
        exp_d.push_back('{done_cyc, port, 1, 0, 0, 0});
        fin = 1'b1;
      end else if (i == MAX_RETRY) begin
        done_cyc = s + r.lat + 1;
        exp_d.push_back('{done_cyc, port, 0, 0, 0, 0});
        fin = 1'b1;
      end else begin
        s = s + r.lat + BACKOFF + 1;
      end
    end
  endtask

  task automatic request(input int port, input int typ);
    if (port == 0) begin
      req0_type = 3'(typ);
      req0_en   = 1'b1;
    end else begin
      req1_type = 3'(typ);
      req1_en   = 1'b1;
    end
  endtask

  task automatic release_on_done(input int port, input string tag);
    int base;
    int n;
    base = (port == 0) ? done_cnt0 : done_cnt1;
    n = 0;
    while ((((port == 0) ? done_cnt0 : done_cnt1) == base) && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    check({tag, " done_seen"}, int'(((port == 0) ? done_cnt0 : done_cnt1) != base), 1);
    if (port == 0) req0_en = 1'b0;
    else           req1_en = 1'b0;
  endtask

  task automatic compare_events(input string tag);
    int ns, nd;
    check({tag, " n_strobe"}, obs_s.size(), exp_s.size());
    ns = (obs_s.size() < exp_s.size()) ? obs_s.size() : exp_s.size();
    for (int i = 0; i < ns; i++) begin
      check($sformatf("%s strobe%0d cyc", tag, i),   obs_s[i].cyc,   exp_s[i].cyc);
      check($sformatf("%s strobe%0d type", tag, i),  obs_s[i].typ,   exp_s[i].typ);
      check($sformatf("%s strobe%0d owner", tag, i), obs_s[i].owner, exp_s[i].owner);
      check($sformatf("%s strobe%0d busy", tag, i),  obs_s[i].busy,  exp_s[i].busy);
    end
    check({tag, " n_done"}, obs_d.size(), exp_d.size());
    nd = (obs_d.size() < exp_d.size()) ? obs_d.size() : exp_d.size();
    for (int i = 0; i < nd; i++) begin
      check($sformatf("%s done%0d cyc", tag, i),     obs_d[i].cyc,  exp_d[i].cyc);
      check($sformatf("%s done%0d port", tag, i),    obs_d[i].port, exp_d[i].port);
      check($sformatf("%s done%0d result", tag, i),  obs_d[i].res,  exp_d[i].res);
      check($sformatf("%s done%0d timeout", tag, i), obs_d[i].to,   exp_d[i].to);
      check($sformatf("%s done%0d busy", tag, i),    obs_d[i].busy, exp_d[i].busy);
      check($sformatf("%s done%0d dual", tag, i),    obs_d[i].dual, exp_d[i].dual);
    end
    obs_s.delete();
    exp_s.delete();
    obs_d.delete();
    exp_d.delete();
    plan.delete();
    mplan.delete();
  endtask

  initial begin
    int c, s, t, d0, d1, p, typ;

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("reset outputs", outs_vec(), 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single send: done returned 10 cycles after the strobe.
    add_plan(10, 1);
    @(negedge clk);
    c = cyc;
    request(1, PKT_SOP);
    model_txn(c + 2, 1, PKT_SOP, d0);
    release_on_done(1, "single");
    repeat (5) @(negedge clk);
    compare_events("single");

    // Priority: both ports request together, port 0 first, port 1 two cycles after done0.
    add_plan(8, 1);
    add_plan(6, 1);
    @(negedge clk);
    c = cyc;
    request(0, PKT_HARD_RESET);
    request(1, PKT_SOP_P);
    model_txn(c + 2, 0, PKT_HARD_RESET, d0);
    model_txn(d0 + 2, 1, PKT_SOP_P, d1);
    release_on_done(0, "prio0");
    release_on_done(1, "prio1");
    repeat (5) @(negedge clk);
    compare_events("priority");

    // Retry exhaustion: three failing attempts.
    add_plan(5, 0);
    add_plan(9, 0);
    add_plan(3, 0);
    @(negedge clk);
    c = cyc;
    request(1, PKT_SOP_PP);
    model_txn(c + 2, 1, PKT_SOP_PP, d0);
    release_on_done(1, "retry");
    repeat (5) @(negedge clk);
    compare_events("retry");

    // Receive deferral of port 1 for 50 cycles.
    add_plan(7, 1);
    @(negedge clk);
    c = cyc;
    rx_busy = 1'b1;
    request(1, PKT_BIST);
    repeat (50) @(negedge clk);
    rx_busy = 1'b0;
    model_txn(c + 52, 1, PKT_BIST, d0);
    release_on_done(1, "defer1");
    repeat (5) @(negedge clk);
    compare_events("defer1");

    // Port 0 is not deferred by a receive.
    add_plan(4, 1);
    @(negedge clk);
    c = cyc;
    rx_busy = 1'b1;
    request(0, PKT_CABLE_RESET);
    model_txn(c + 2, 0, PKT_CABLE_RESET, d0);
    release_on_done(0, "defer0");
    rx_busy = 1'b0;
    repeat (5) @(negedge clk);
    compare_events("defer0");

    // Done exactly at expiry wins over the timeout.
    add_plan(TO, 1);
    @(negedge clk);
    c = cyc;
    request(0, PKT_HARD_RESET);
    model_txn(c + 2, 0, PKT_HARD_RESET, d0);
    release_on_done(0, "to_edge");
    repeat (5) @(negedge clk);
    compare_events("to_edge");

    // One cycle late is a timeout; the late done is ignored and the flag stays set.
    add_plan(TO + 1, 1);
    @(negedge clk);
    c = cyc;
    request(1, PKT_SOP);
    model_txn(c + 2, 1, PKT_SOP, d0);
    release_on_done(1, "timeout");
    repeat (5) @(negedge clk);
    check("timeout sticky", int'(timeout_flag), 1);
    compare_events("timeout");

    // Preemption of port 1 in backoff by port 0.
    add_plan(5, 0);
    add_plan(4, 1);
    @(negedge clk);
    c = cyc;
    request(1, PKT_SOP);
    s = c + 2;
    t = s + 5;
    exp_s.push_back('{s, int'(PKT_SOP), 1, 1});
    void'(mplan.pop_front());
    while (cyc < t + 10) @(negedge clk);
    request(0, PKT_HARD_RESET);
    exp_d.push_back('{t + 12, 1, 0, 0, 0, 0});
    model_txn(t + 14, 0, PKT_HARD_RESET, d0);
    release_on_done(1, "preempt1");
    release_on_done(0, "preempt0");
    repeat (5) @(negedge clk);
    compare_events("preempt");

    // Reset while waiting for done: outputs clear, no done pulse, then normal service.
    add_plan(12, 1);
    @(negedge clk);
    c = cyc;
    request(1, PKT_SOP_PP);
    s = c + 2;
    exp_s.push_back('{s, int'(PKT_SOP_PP), 1, 1});
    while (cyc < s + 5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset outputs", outs_vec(), 0);
    rst = 1'b0;
    req1_en = 1'b0;
    repeat (20) @(negedge clk);
    compare_events("reset_mid");

    add_plan(3, 1);
    @(negedge clk);
    c = cyc;
    request(1, PKT_SOP);
    model_txn(c + 2, 1, PKT_SOP, d0);
    release_on_done(1, "after_reset");
    repeat (5) @(negedge clk);
    compare_events("after_reset");

    // Randomized transactions.
    for (int k = 0; k < 14; k++) begin
      p   = int'($urandom_range(0, 1));
      typ = int'($urandom_range(0, 5));
      for (int i = 0; i <= MAX_RETRY; i++)
        add_plan(int'($urandom_range(1, LAT_MAX)), ($urandom_range(0, 99) < 35) ? 1 : 0);
      @(negedge clk);
      c = cyc;
      request(p, typ);
      model_txn(c + 2, p, typ, d0);
      release_on_done(p, $sformatf("rand%0d", k));
      repeat (5) @(negedge clk);
      compare_events($sformatf("rand%0d", k));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
